// File: rtl/decoder_scan_sequencer_pkg.sv
// Shared definitions for the decoder scan sequencer: state encodings and channel geometry.
package decoder_scan_sequencer_pkg;

  localparam int                NUM_CH   = 8;
  localparam int                SEL_W    = 3;
  localparam logic [NUM_CH-1:0] MASK_ALL = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/decoder_scan_sequencer_scan_next_sel.sv
// Combinational search for the next enabled channel after cur, wrapping to the lowest one.
// With cur = 7 it returns the first enabled channel of a frame (wrap is then meaningless).
module scan_next_sel
  import decoder_scan_sequencer_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  output logic [SEL_W-1:0]  nxt,
  output logic              wrap,
  output logic              none
);

  logic             found_hi;
  logic [SEL_W-1:0] hi;
  logic [SEL_W-1:0] lo;

  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    found_hi = 1'b0;
    hi       = '0;
    lo       = '0;
    // Descending walk: the last hit seen is the smallest qualifying index.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (!mask[i]) begin
        lo = SEL_W'(i);
        if (i > int'(cur)) begin
          hi       = SEL_W'(i);
          found_hi = 1'b1;
        end
      end
    end
    none = (mask == MASK_ALL);
    wrap = !found_hi;
    nxt  = found_hi ? hi : lo;
  end

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Round-robin scan sequencer driving a 3-to-8 active-low-enable decoder (sel / en_n).
// Build with SCAN_BLANK_GAP_EN defined to insert one blanked cycle between channel windows.
module decoder_scan_sequencer
  import decoder_scan_sequencer_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [NUM_CH-1:0]  mask,
  output logic [SEL_W-1:0]   sel,
  output logic               en_n,
  output logic               chan_done,
  output logic               frame_done,
  output logic               busy
);

  state_t             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               en_n_q, en_n_d;
  logic               busy_q, busy_d;
  logic               stop_pend_q, stop_pend_d;
  logic               chan_done_q, frame_done_q;
  logic [SEL_W-1:0]   nxt_q;
  logic               none_q;
  logic               last_d;

  logic [SEL_W-1:0]   first_sel;
  logic               first_wrap_unused;
  logic               first_none;
  logic [SEL_W-1:0]   nx_sel;
  logic               nx_wrap;
  logic               nx_none;
  logic [DWELL_W-1:0] dwell_ld;

  assign dwell_ld = (dwell == '0) ? DWELL_W'(1) : dwell;

  scan_next_sel u_first (
    .mask (mask),
    .cur  (SEL_W'(NUM_CH - 1)),
    .nxt  (first_sel),
    .wrap (first_wrap_unused),
    .none (first_none)
  );

  // Successor of the channel whose last active cycle is about to start; the mask seen on
  // that edge fixes frame_done for the window and the channel that follows it.
  scan_next_sel u_next (
    .mask (mask),
    .cur  (sel_d),
    .nxt  (nx_sel),
    .wrap (nx_wrap),
    .none (nx_none)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    en_n_d      = en_n_q;
    busy_d      = busy_q;
    stop_pend_d = stop_pend_q | (busy_q & stop);
    case (state_q)
      ST_IDLE: begin
        if (start && !stop && !first_none) begin
          state_d = ST_SCAN;
          sel_d   = first_sel;
          cnt_d   = dwell_ld;
          en_n_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_SCAN: begin
        if (cnt_q > DWELL_W'(1)) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (stop_pend_d || none_q) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          en_n_d      = 1'b1;
          busy_d      = 1'b0;
          stop_pend_d = 1'b0;
        end else begin
`ifdef SCAN_BLANK_GAP_EN
          state_d = ST_GAP;
          sel_d   = nxt_q;
          cnt_d   = '0;
          en_n_d  = 1'b1;
`else
          sel_d   = nxt_q;
          cnt_d   = dwell_ld;
`endif
        end
      end
`ifdef SCAN_BLANK_GAP_EN
      ST_GAP: begin
        state_d = ST_SCAN;
        cnt_d   = dwell_ld;
        en_n_d  = 1'b0;
      end
`endif
      default: begin
        state_d     = ST_IDLE;
        cnt_d       = '0;
        en_n_d      = 1'b1;
        busy_d      = 1'b0;
        stop_pend_d = 1'b0;
      end
    endcase
    last_d = (state_d == ST_SCAN) && (cnt_d == DWELL_W'(1));
  end

  // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sel_q        <= '0;
      en_n_q       <= 1'b1;
      busy_q       <= 1'b0;
      stop_pend_q  <= 1'b0;
      chan_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      nxt_q        <= '0;
      none_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      en_n_q       <= en_n_d;
      busy_q       <= busy_d;
      stop_pend_q  <= stop_pend_d;
      chan_done_q  <= last_d;
      frame_done_q <= last_d & (nx_wrap | nx_none);
      if (last_d) begin
        nxt_q  <= nx_sel;
        none_q <= nx_none;
      end
    end
  end

  assign sel        = sel_q;
  assign en_n       = en_n_q;
  assign chan_done  = chan_done_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: doc/decoder_scan_sequencer.md
Name: decoder_scan_sequencer

Overview:
- Upstream driver for the 3-to-8 active-low-enable decoder. Generates the 3-bit select code and the active-low enable.
- Steps round-robin through channels 0..7 and skips masked channels. Holds each channel for a programmable dwell time.
- Typical use: display or row multiplexing. sel feeds the decoder select input, en_n feeds the decoder enable.

Parameters:
- DWELL_W, 8, width of the dwell-count input and the internal dwell counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to begin scanning; sampled in IDLE only
- stop  input  1  request to end scanning after the current channel window
- dwell  input  DWELL_W  active cycles per channel; sampled at each channel load
- mask  input  8  per-channel skip mask; 1 = skip channel
- sel  output  3  current channel code to the decoder
- en_n  output  1  active-low decoder enable; 0 while a channel window is active
- chan_done  output  1  one-cycle pulse on the last active cycle of each channel window
- frame_done  output  1  one-cycle pulse when the scan wraps past the highest enabled channel
- busy  output  1  high from the first active cycle until return to IDLE

Behaviour:
- Reset (synchronous, rst=1 at a clock edge) gives: state IDLE, sel=0, en_n=1, chan_done=0, frame_done=0, busy=0, dwell counter=0. Reset overrides all other inputs and aborts any window immediately.
- All outputs are registered.
- States: IDLE and SCAN, plus GAP when the optional feature is built in.
- IDLE -> SCAN: start=1, stop=0 and mask!=8'hFF.
  - Next cycle: sel = lowest index with mask bit 0, en_n=0, busy=1.
  - Counter loads max(dwell,1); dwell=0 is treated as 1.
- IDLE with start=1 and mask=8'hFF: ignored, stays IDLE. start and stop in the same IDLE cycle: stop wins.
- start while busy: ignored.
- SCAN: the counter decrements each cycle. A window lasts exactly max(dwell,1) cycles with en_n=0.
- Last cycle of a window: chan_done=1. The next channel is the smallest enabled index greater than sel; if none exists, it is the smallest enabled index overall (wrap).
  - On wrap, frame_done=1 in the same cycle as chan_done.
  - One enabled channel: it re-selects itself and frame_done pulses every window.
- Next channel loads on the following cycle with no gap: en_n stays 0 and dwell is re-sampled.
- stop is latched as pending on any cycle while busy. At the end of the current window the block goes to IDLE.
  - Returning to IDLE gives en_n=1, busy=0, and sel holds its last value. chan_done still pulses; frame_done pulses only if that window would have wrapped.
- mask is re-evaluated only at window end. If it is all ones then, the block returns to IDLE with frame_done=1.
- mask and dwell changes mid-window do not affect the current window.

Optional Feature:
- Macro: SCAN_BLANK_GAP_EN.
- Defined: one GAP cycle follows every window before the next channel. During GAP, en_n=1 (anti-ghosting) and sel already holds the next channel code. chan_done and frame_done pulse on the last active cycle, not in GAP. stop or an all-ones mask goes straight to IDLE without a GAP cycle.
- Undefined: windows are back-to-back with en_n continuously 0 while scanning. No GAP state is built.

Decomposition:
- Shared package/include:
  - state encodings (ST_IDLE, ST_SCAN, ST_GAP)
  - NUM_CH=8, SEL_W=3
  - MASK_ALL=8'hFF
- Sub-module scan_next_sel: purely combinational.
  - Inputs: mask[7:0], cur[2:0].
  - Outputs: nxt[2:0], wrap, none (mask all ones).
  - Also used to find the first channel by passing cur=7 with wrap ignored.

Test Plan:
- rst=1 for 2 cycles, then release -> sel=0, en_n=1, busy=0, chan_done=0, frame_done=0.
- mask=8'h00, dwell=2, start pulse -> sel 0,0,1,1,...,7,7,0 with en_n=0 throughout; chan_done every 2nd cycle; frame_done with the chan_done of channel 7.
- mask=8'b1010_1101, dwell=1 -> sel sequence 1,4,6,1,4,6; frame_done on each channel-6 window.
- mask=8'hFF, start -> stays IDLE, en_n=1. Then mask=8'hEF, dwell=0 -> sel=4 every cycle, frame_done high every cycle.
- Scan with dwell=5, stop asserted on cycle 2 of the channel 3 window -> window completes (5 cycles), chan_done, then en_n=1, busy=0, sel=3. A start in the same cycle as stop is ignored.
- Mid-window rst=1 -> next edge: en_n=1, sel=0, no chan_done pulse. With SCAN_BLANK_GAP_EN: one en_n=1 cycle between windows, with sel already at the next channel.
